// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_if
// Description : Request/result bundle between the EXE stage and the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, hi, lo, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative HI/LO multiply/divide unit, one bit per clock
//               (shift-add multiply, restoring divide), WIDTH+1 cycles busy.
//               Define MULT_DIV_SIGNED_EN to enable signed MULT/DIV (op 00/10).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input wire logic  clk,
  input wire logic  rst,
  mult_div_if.slave bus
);

  localparam int                c_cnt_w     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_is_div;
  logic [WIDTH-1:0]     r_rs_raw;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic [WIDTH-1:0]     w_abs_rs;
  logic [WIDTH-1:0]     w_abs_rt;

`ifdef MULT_DIV_SIGNED_EN
  logic r_neg_main;  // product / quotient sign
  logic r_neg_rem;   // remainder follows dividend sign
  logic w_signed;
  logic w_neg_main;
  logic w_neg_rem;

  always_comb begin
    w_signed   = ~bus.op[0];
    w_abs_rs   = (w_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    w_abs_rt   = (w_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    w_neg_main = w_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
    w_neg_rem  = w_signed & bus.rs_val[WIDTH-1];
  end
`else
  logic w_unused_op0;
  assign w_unused_op0 = bus.op[0];
  assign w_abs_rs     = bus.rs_val;
  assign w_abs_rt     = bus.rt_val;
`endif

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_step;

  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_b});
    w_diff    = w_rem_sh[WIDTH-1:0] - r_b;
    if (r_is_div) begin
      w_step = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end else begin
      w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  always_comb begin
    w_prod = w_step;
    w_quo  = w_step[WIDTH-1:0];
    w_rem  = w_step[2*WIDTH-1:WIDTH];
`ifdef MULT_DIV_SIGNED_EN
    if (r_neg_main) begin
      w_prod = -w_step;
      w_quo  = -w_step[WIDTH-1:0];
    end
    if (r_neg_rem) begin
      w_rem = -w_step[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_rs_raw   <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef MULT_DIV_SIGNED_EN
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_is_div   <= bus.op[1];
            r_rs_raw   <= bus.rs_val;
            r_b        <= w_abs_rt;
            r_acc      <= {{WIDTH{1'b0}}, w_abs_rs};
`ifdef MULT_DIV_SIGNED_EN
            r_neg_main <= w_neg_main;
            r_neg_rem  <= w_neg_rem;
`endif
          end
        end
        RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_step) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_prod;
              r_dbz        <= 1'b0;
            end else if (r_b == '0) begin
              r_hi  <= r_rs_raw;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi  <= w_rem;
              r_lo  <= w_quo;
              r_dbz <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit; honours MULT_DIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          issue_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  mult_div_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    bit              sgn;
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
`ifdef MULT_DIV_SIGNED_EN
    sgn = !op[0];
`else
    sgn = 1'b0;
`endif
    e.dbz = 1'b0;
    e.issue_cyc = 0;
    sa = $signed(a);
    sb = $signed(b);
    if (!op[1]) begin
      if (sgn) begin
        sp = sa * sb;
        {e.hi, e.lo} = sp;
      end else begin
        up = a;
        up = up * b;
        {e.hi, e.lo} = up;
      end
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
      e.lo = sq[31:0];
      e.hi = sr[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 200) begin
      @(negedge clk);
      w = w + 1;
    end
    check("issue_wait_idle", {63'd0, bus.busy}, 64'd0);
    #1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    e = model(op, a, b);
    e.issue_cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // A start pulse that the busy unit must ignore.
  task automatic pulse_ignored(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    #1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Monitor: pops the scoreboard on done, checks hold behaviour and busy length.
  logic [31:0] prev_hi, prev_lo;
  logic        prev_dbz;
  bit          prev_ok = 1'b0;
  int          busy_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
          check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
          check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
          check("done_latency", 64'(cyc - e.issue_cyc), 64'(WIDTH));
        end
      end else if (prev_ok) begin
        check("hold_hi_lo", {bus.hi, bus.lo}, {prev_hi, prev_lo});
        check("hold_dbz", {63'd0, bus.div_by_zero}, {63'd0, prev_dbz});
      end
      if (bus.busy) begin
        busy_run = busy_run + 1;
      end else if (busy_run > 0) begin
        check("busy_length", 64'(busy_run), 64'(WIDTH + 1));
        busy_run = 0;
      end
    end
    prev_hi  = bus.hi;
    prev_lo  = bus.lo;
    prev_dbz = bus.div_by_zero;
    prev_ok  = 1'b1;
  end

  initial begin
    int w;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    #1 rst = 1'b0;

    // Directed corner cases
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'd7, 32'd2);
    issue(2'b11, 32'd100, 32'd0);
    issue(2'b01, 32'd2, 32'd3);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FF00, 32'd0);
    issue(2'b10, 32'd9, 32'hFFFF_FFFE);

    // Starts while busy must not disturb the running operation
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(negedge clk);
    pulse_ignored(2'b11, 32'd55, 32'd5);
    repeat (4) @(negedge clk);
    pulse_ignored(2'b00, 32'hFFFF_FFFF, 32'd1);

    // Asynchronous reset mid-RUN discards the operation
    issue(2'b11, 32'hDEAD_BEEF, 32'h0000_1000);
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete(exp_q.size() - 1);
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("abort_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    issue(2'b11, 32'd1000, 32'd7);

    // Randomized traffic, mostly back-to-back
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      issue(rop, ra, rb);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 4 * WIDTH) begin
      @(negedge clk);
      w = w + 1;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
